csr_user_trap: RTL and testbench
================================

# csr_user_trap

User-mode (N-extension) CSR unit with XLEN-parametrised registers, read-modify-write CSR operations, WARL field masking, and atomic trap-entry/`uret` sequencing. It sits beside the execute stage. It services CSR instructions, latches user interrupt sources, and produces a registered PC redirect for the fetch stage on trap entry and return.

## Interface
- `XLEN`, 64: register width, 32 or 64.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `csr_op`  in  2  00 none, 01 RW (write), 10 RS (set), 11 RC (clear).
- `csr_addr`  in  12  CSR address.
- `csr_wdata`  in  XLEN  operand (rs1 value or zero-extended immediate).
- `csr_rdata`  out  XLEN  old value at `csr_addr` (combinational).
- `csr_illegal`  out  1  combinational; high for an unknown address, or for a write to a read-only CSR, when `csr_op`≠00.
- `trap_valid`  in  1  trap entry request.
- `trap_cause`  in  XLEN  cause; MSB=1 means interrupt.
- `trap_pc`  in  XLEN  PC of the faulting/interrupted instruction.
- `trap_val`  in  XLEN  trap value.
- `uret_valid`  in  1  `uret` executed.
- `irq_soft_set`  in  1  pulse; sets USIP.
- `irq_timer`, `irq_ext`  in  1 each  level interrupt inputs.
- `irq_req`  out  1  registered; interrupt ready to be taken.
- `redirect_valid`  out  1  one-cycle pulse.
- `redirect_pc`  out  XLEN  redirect target.

## Operation
- **Registers and addresses:** ustatus 0x000, uie 0x004, utvec 0x005, uscratch 0x040, uepc 0x041, ucause 0x042, utval 0x043, uip 0x044.
- **WARL masks:**
  - ustatus keeps only UIE(0) and UPIE(4).
  - uie keeps bits 0, 4 and 8.
  - utvec keeps [XLEN-1:2] plus mode bit 0; bit 1 reads 0.
  - uepc[1:0] read 0.
  - uscratch, ucause and utval are full width.
- **uip bits:**
  - USIP(0) is software-writable and is also set by `irq_soft_set`.
  - UTIP(4) and UEIP(8) mirror registered `irq_timer` and `irq_ext`; writes to them are ignored.
- **Write value:**
  - RW writes `wdata`.
  - RS writes `old | wdata`.
  - RC writes `old & ~wdata`.
  - RS/RC with `csr_wdata`==0 perform no write and are never illegal on read-only CSRs.
  - Illegal accesses do not write.
- **Trap entry:**
  - uepc←`trap_pc`, ucause←`trap_cause`, utval←`trap_val`, UPIE←UIE, UIE←0.
  - Redirect target is utvec base (utvec & ~3).
  - If mode=1 and `trap_cause` MSB=1, the target is base + 4·cause[XLEN-2:0].
- **`uret`:** UIE←UPIE, UPIE←1, redirect target is uepc.
- **Interrupt request:** `irq_req` = UIE & |(uie & uip), registered.
- **Priority (same cycle):**
  - `trap_valid` beats `uret_valid`, and either beats a CSR write; the losing CSR write is dropped.
  - A CSR write to uip beats `irq_soft_set` on USIP.
- **FSM:**
  - RUN: on trap or `uret`, go to REDIR.
  - REDIR: assert `redirect_valid` for one cycle, then return to RUN.
  - A `trap_valid` or `uret_valid` arriving in REDIR is processed normally (back-to-back allowed); the FSM stays in REDIR, issuing another pulse.

## Timing
- Reset values: all CSRs 0, FSM=RUN, `redirect_valid`=0, `redirect_pc`=0, `irq_req`=0, interrupt input registers 0.
- `csr_rdata`/`csr_illegal` are combinational in the same cycle; a CSR write is visible on the next cycle.
- Trap or `uret` in cycle N:
  - CSRs update at the N→N+1 edge.
  - `redirect_valid`=1 with `redirect_pc` in cycle N+1 only.
- `irq_timer`/`irq_ext` reach uip 1 cycle after the input change; `irq_req` follows 1 cycle later (2-cycle latency).
- `rst` asserted in any state, including REDIR, returns everything to reset values at the next edge; a pending redirect pulse is cancelled.
- XLEN=32: counters keep full 64 bits; the high halves appear at 0xC80/0xC82.

## Configuration
- `CSR_USER_COUNTERS_EN` defined:
  - Adds read-only `cycle` (0xC00), incrementing every non-reset cycle.
  - Adds `instret` (0xC02), incremented by input `instr_retire` (1 bit, port present only with the macro).
  - Both counters are 64-bit, wrap to 0 after all-ones, and reset to 0.
  - RW (or nonzero RS/RC) to them raises `csr_illegal`.
- Undefined: these addresses are unknown, so any access with `csr_op`≠00 raises `csr_illegal` and reads return 0.

## Test plan
- RW 0x040 ←0xDEAD_BEEF, then RS 0x040 with 0xF0, then RC with 0x0F → reads return 0xDEAD_BEEF, then 0xDEAD_BEFF, and final value 0xDEAD_BEF0.
- RW ustatus ←all-ones → reads 0x11; RW uie ←all-ones → reads 0x111; RW uip bit 4 → still 0 while `irq_timer`=0.
- ustatus=0x1, utvec=0x8001; trap with cause=(1<<XLEN-1)|4, pc=0x1002 → cycle N+1 pulse with `redirect_pc`=0x8010; uepc=0x1000, ustatus=0x10. Then `uret` → `redirect_pc`=0x1000, ustatus=0x11.
- uie=0x100, UIE=1; raise `irq_ext` at cycle N → `irq_req`=1 at N+2; drop it → `irq_req`=0 two cycles later.
- Trap, `uret` and RW uscratch in the same cycle → trap applied, uscratch unchanged; reset during REDIR → no pulse, all CSRs 0.
- With the macro: `cycle` increments by 1 per clock after reset; RW to 0xC00 → `csr_illegal`=1, value unchanged. Without the macro: reading 0xC00 → `csr_illegal`=1, `csr_rdata`=0.

Source files
------------

// File: rtl/csr_user_trap.sv
// User-mode CSR file with WARL masking, read-modify-write ops, trap entry / uret
// sequencing and a registered fetch redirect. Define CSR_USER_COUNTERS_EN to add cycle/instret.
module csr_user_trap #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      csr_op,
   input  logic [11:0]     csr_addr,
   input  logic [XLEN-1:0] csr_wdata,
   output logic [XLEN-1:0] csr_rdata,
   output logic            csr_illegal,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_cause,
   input  logic [XLEN-1:0] trap_pc,
   input  logic [XLEN-1:0] trap_val,
   input  logic            uret_valid,
   input  logic            irq_soft_set,
   input  logic            irq_timer,
   input  logic            irq_ext,
`ifdef CSR_USER_COUNTERS_EN
   input  logic            instr_retire,
`endif
   output logic            irq_req,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc
);

   localparam logic [11:0] A_USTATUS  = 12'h000;
   localparam logic [11:0] A_UIE      = 12'h004;
   localparam logic [11:0] A_UTVEC    = 12'h005;
   localparam logic [11:0] A_USCRATCH = 12'h040;
   localparam logic [11:0] A_UEPC     = 12'h041;
   localparam logic [11:0] A_UCAUSE   = 12'h042;
   localparam logic [11:0] A_UTVAL    = 12'h043;
   localparam logic [11:0] A_UIP      = 12'h044;
`ifdef CSR_USER_COUNTERS_EN
   localparam logic [11:0] A_CYCLE    = 12'hC00;
   localparam logic [11:0] A_INSTRET  = 12'hC02;
   localparam logic [11:0] A_CYCLEH   = 12'hC80;
   localparam logic [11:0] A_INSTRETH = 12'hC82;
`endif

   localparam logic [1:0] OP_NONE = 2'b00;
   localparam logic [1:0] OP_RW   = 2'b01;
   localparam logic [1:0] OP_RS   = 2'b10;

   typedef enum logic {RUN, REDIR} state_t;

   state_t          state;
   logic            st_uie, st_upie, usip, tim_q, ext_q;
   logic [XLEN-1:0] uie_r, utvec_r, uscratch_r, uepc_r, ucause_r, utval_r;
   logic [XLEN-1:0] ustatus_v, uip_v, wval, base, trap_tgt;
   logic            known, ro, is_wr, csr_we;

`ifdef CSR_USER_COUNTERS_EN
   logic [63:0] cycle_q, instret_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_q   <= '0;
         instret_q <= '0;
      end else begin
         cycle_q   <= cycle_q + 64'd1;
         instret_q <= instret_q + 64'(instr_retire);
      end
   end
`endif

   assign ustatus_v = XLEN'({st_upie, 3'b000, st_uie});
   assign uip_v     = XLEN'({ext_q, 3'b000, tim_q, 3'b000, usip});

   always_comb begin
      csr_rdata = '0;
      known     = 1'b1;
      ro        = 1'b0;
      case (csr_addr)
         A_USTATUS:  csr_rdata = ustatus_v;
         A_UIE:      csr_rdata = uie_r;
         A_UTVEC:    csr_rdata = utvec_r;
         A_USCRATCH: csr_rdata = uscratch_r;
         A_UEPC:     csr_rdata = uepc_r;
         A_UCAUSE:   csr_rdata = ucause_r;
         A_UTVAL:    csr_rdata = utval_r;
         A_UIP:      csr_rdata = uip_v;
`ifdef CSR_USER_COUNTERS_EN
         A_CYCLE: begin
            csr_rdata = XLEN'(cycle_q);
            ro        = 1'b1;
         end
         A_INSTRET: begin
            csr_rdata = XLEN'(instret_q);
            ro        = 1'b1;
         end
         // High halves exist only on RV32; RV64 reads the full counter above.
         A_CYCLEH: begin
            if (XLEN == 32) csr_rdata = XLEN'(cycle_q >> 32);
            else            known     = 1'b0;
            ro = 1'b1;
         end
         A_INSTRETH: begin
            if (XLEN == 32) csr_rdata = XLEN'(instret_q >> 32);
            else            known     = 1'b0;
            ro = 1'b1;
         end
`endif
         default: known = 1'b0;
      endcase
   end

   // RS/RC with a zero operand are pure reads, so they are legal on read-only CSRs.
   assign is_wr       = (csr_op == OP_RW) || (csr_wdata != '0);
   assign csr_illegal = (csr_op != OP_NONE) && (!known || (ro && is_wr));
   assign csr_we      = (csr_op != OP_NONE) && is_wr && !csr_illegal && !trap_valid && !uret_valid;

   always_comb begin
      case (csr_op)
         OP_RW:   wval = csr_wdata;
         OP_RS:   wval = csr_rdata | csr_wdata;
         default: wval = csr_rdata & ~csr_wdata;
      endcase
   end

   assign base     = utvec_r & ~XLEN'(3);
   assign trap_tgt = (utvec_r[0] && trap_cause[XLEN-1]) ? base + XLEN'(trap_cause << 2) : base;

   always_ff @(posedge clk) begin
      if (rst) begin
         st_uie     <= 1'b0;
         st_upie    <= 1'b0;
         usip       <= 1'b0;
         tim_q      <= 1'b0;
         ext_q      <= 1'b0;
         irq_req    <= 1'b0;
         uie_r      <= '0;
         utvec_r    <= '0;
         uscratch_r <= '0;
         uepc_r     <= '0;
         ucause_r   <= '0;
         utval_r    <= '0;
      end else begin
         tim_q   <= irq_timer;
         ext_q   <= irq_ext;
         irq_req <= st_uie & (|(uie_r & uip_v));
         if (csr_we && csr_addr == A_UIP) usip <= wval[0];
         else if (irq_soft_set)           usip <= 1'b1;
         if (trap_valid) begin
            uepc_r   <= trap_pc & ~XLEN'(3);
            ucause_r <= trap_cause;
            utval_r  <= trap_val;
            st_upie  <= st_uie;
            st_uie   <= 1'b0;
         end else if (uret_valid) begin
            st_uie  <= st_upie;
            st_upie <= 1'b1;
         end else if (csr_we) begin
            case (csr_addr)
               A_USTATUS: begin
                  st_uie  <= wval[0];
                  st_upie <= wval[4];
               end
               A_UIE:      uie_r      <= wval & XLEN'(12'h111);
               A_UTVEC:    utvec_r    <= wval & ~XLEN'(2);
               A_USCRATCH: uscratch_r <= wval;
               A_UEPC:     uepc_r     <= wval & ~XLEN'(3);
               A_UCAUSE:   ucause_r   <= wval;
               A_UTVAL:    utval_r    <= wval;
               default: ;
            endcase
         end
      end
   end

   // A new trap/uret while in REDIR simply re-arms the pulse with the new target.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= RUN;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
      end else if (trap_valid) begin
         state          <= REDIR;
         redirect_valid <= 1'b1;
         redirect_pc    <= trap_tgt;
      end else if (uret_valid) begin
         state          <= REDIR;
         redirect_valid <= 1'b1;
         redirect_pc    <= uepc_r;
      end else if (state == REDIR) begin
         state          <= RUN;
         redirect_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_csr_user_trap.sv
// Randomised scoreboard bench for csr_user_trap: a cycle-level reference model pushes
// expectations into queues, and a negedge monitor pops and compares them.
module tb_csr_user_trap;
   localparam int XLEN = 64;
   typedef logic [63:0] w_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [1:0]   csr_op = '0;
   logic [11:0]  csr_addr = '0;
   w_t           csr_wdata = '0, csr_rdata;
   logic         csr_illegal;
   logic         trap_valid = 1'b0, uret_valid = 1'b0;
   w_t           trap_cause = '0, trap_pc = '0, trap_val = '0;
   logic         irq_soft_set = 1'b0, irq_timer = 1'b0, irq_ext = 1'b0;
   logic         instr_retire = 1'b0;
   logic         irq_req, redirect_valid;
   w_t           redirect_pc;

   csr_user_trap #(.XLEN(XLEN)) dut (
      .clk(clk), .rst(rst), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
      .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .trap_valid(trap_valid),
      .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_val(trap_val), .uret_valid(uret_valid),
      .irq_soft_set(irq_soft_set), .irq_timer(irq_timer), .irq_ext(irq_ext),
`ifdef CSR_USER_COUNTERS_EN
      .instr_retire(instr_retire),
`endif
      .irq_req(irq_req), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {int c; w_t data; logic flag;} exp_t;
   exp_t csr_q[$], red_q[$], irq_q[$];
   int checks = 0, errors = 0;

   task automatic chk(input string nm, input w_t act, input w_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   // Architectural state of the reference model, one variable per CSR.
   w_t ustatus, uie, utvec, uscratch, uepc, ucause, utval;
   bit usip, tim, ext;
   longint unsigned m_cycle, m_instret;

   function automatic w_t m_read(input logic [11:0] a, output bit known, output bit ro);
      known = 1; ro = 0;
      case (a)
         12'h000: return ustatus;
         12'h004: return uie;
         12'h005: return utvec;
         12'h040: return uscratch;
         12'h041: return uepc;
         12'h042: return ucause;
         12'h043: return utval;
         12'h044: return w_t'(usip) | (w_t'(tim) << 4) | (w_t'(ext) << 8);
`ifdef CSR_USER_COUNTERS_EN
         12'hC00: begin ro = 1; return m_cycle; end
         12'hC02: begin ro = 1; return m_instret; end
`endif
         default: begin known = 0; return 0; end
      endcase
   endfunction

   // Evaluate one cycle of the model with the currently driven inputs, then advance the clock.
   task automatic step();
      w_t old, nv, tgt, uip;
      bit known, ro, wr, ill, exp_irq, uip_wr;
      old = m_read(csr_addr, known, ro);
      wr  = (csr_op == 2'b01) || (csr_wdata != 0);
      ill = !known || (ro && wr);
      if (csr_op != 0) csr_q.push_back('{cyc, old, ill});
      uip = w_t'(usip) | (w_t'(tim) << 4) | (w_t'(ext) << 8);
      exp_irq = ustatus[0] && ((uie & uip) != 0);
      if (rst) begin
         {ustatus, uie, utvec, uscratch, uepc, ucause, utval} = '0;
         {usip, tim, ext} = '0;
         m_cycle = 0; m_instret = 0;
         irq_q.push_back('{cyc + 1, 0, 1'b0});
      end else begin
         irq_q.push_back('{cyc + 1, 0, exp_irq});
         uip_wr = 0;
         if (trap_valid) begin
            tgt = utvec - (utvec % 4);
            if (utvec[0] && trap_cause[63]) tgt = tgt + 4 * (trap_cause & ~(64'd1 << 63));
            red_q.push_back('{cyc + 1, tgt, 1'b1});
            uepc = trap_pc - (trap_pc % 4); ucause = trap_cause; utval = trap_val;
            ustatus = ustatus[0] ? 64'h10 : 64'h0;
         end else if (uret_valid) begin
            red_q.push_back('{cyc + 1, uepc, 1'b1});
            ustatus = ustatus[4] ? 64'h11 : 64'h10;
         end else if (csr_op != 0 && wr && !ill) begin
            nv = (csr_op == 2'b01) ? csr_wdata : (csr_op == 2'b10) ? (old | csr_wdata) : (old & ~csr_wdata);
            case (csr_addr)
               12'h000: ustatus  = nv & 64'h11;
               12'h004: uie      = nv & 64'h111;
               12'h005: utvec    = nv & ~64'h2;
               12'h040: uscratch = nv;
               12'h041: uepc     = nv & ~64'h3;
               12'h042: ucause   = nv;
               12'h043: utval    = nv;
               12'h044: begin usip = nv[0]; uip_wr = 1; end
               default: ;
            endcase
         end
         if (!uip_wr && irq_soft_set) usip = 1;
         tim = irq_timer; ext = irq_ext;
         m_cycle++;
         m_instret += instr_retire;
      end
      @(posedge clk); #1;
   endtask

   task automatic csr(input logic [1:0] op, input logic [11:0] a, input w_t d);
      csr_op = op; csr_addr = a; csr_wdata = d;
      step();
      csr_op = 0; csr_wdata = 0;
   endtask

   task automatic trap(input w_t cause, input w_t pc, input w_t val);
      trap_valid = 1; trap_cause = cause; trap_pc = pc; trap_val = val;
      step();
      trap_valid = 0;
   endtask

   task automatic read_all();
      logic [11:0] a[10] = '{12'h000, 12'h004, 12'h005, 12'h040, 12'h041,
                             12'h042, 12'h043, 12'h044, 12'hC00, 12'h123};
      foreach (a[i]) csr(2'b10, a[i], 0);
   endtask

   // Monitor: compares whatever the DUT shows in this cycle against queued expectations.
   always @(negedge clk) begin
      exp_t e;
      bit due;
      if (csr_op != 0 && csr_q.size() > 0) begin
         e = csr_q.pop_front();
         chk("csr_rdata", csr_rdata, e.data);
         chk("csr_illegal", w_t'(csr_illegal), w_t'(e.flag));
      end
      due = red_q.size() > 0 && red_q[0].c == cyc;
      chk("redirect_valid", w_t'(redirect_valid), w_t'(due));
      if (due) begin
         e = red_q.pop_front();
         chk("redirect_pc", redirect_pc, e.data);
      end
      if (irq_q.size() > 0 && irq_q[0].c == cyc) begin
         e = irq_q.pop_front();
         chk("irq_req", w_t'(irq_req), w_t'(e.flag));
      end
   end

   initial begin
      logic [11:0] pool[10] = '{12'h000, 12'h004, 12'h005, 12'h040, 12'h041,
                                12'h042, 12'h043, 12'h044, 12'hC00, 12'hC80};
      @(posedge clk); #1;
      step(); step();
      rst = 0;
      chk("reset_redirect_pc", redirect_pc, 0);
      read_all();
      // scratch read-modify-write
      csr(2'b01, 12'h040, 64'hDEAD_BEEF);
      csr(2'b10, 12'h040, 64'hF0);
      csr(2'b11, 12'h040, 64'h0F);
      csr(2'b10, 12'h040, 0);
      // WARL masks and uip mirror bits
      csr(2'b01, 12'h000, '1); csr(2'b10, 12'h000, 0);
      csr(2'b01, 12'h004, '1); csr(2'b10, 12'h004, 0);
      csr(2'b01, 12'h044, 64'h10); csr(2'b10, 12'h044, 0);
      csr(2'b01, 12'h005, '1); csr(2'b10, 12'h005, 0);
      // vectored trap then uret
      csr(2'b01, 12'h000, 64'h1);
      csr(2'b01, 12'h005, 64'h8001);
      trap((64'd1 << 63) | 64'd4, 64'h1002, 64'h55);
      csr(2'b10, 12'h041, 0);
      csr(2'b10, 12'h000, 0);
      uret_valid = 1; step(); uret_valid = 0;
      csr(2'b10, 12'h000, 0);
      // external interrupt latency
      csr(2'b01, 12'h004, 64'h100);
      csr(2'b01, 12'h000, 64'h1);
      irq_ext = 1; step(); step(); step(); step();
      irq_ext = 0; step(); step(); step();
      // trap + uret + CSR write in one cycle
      trap_valid = 1; uret_valid = 1; trap_cause = 64'h7; trap_pc = 64'h2000;
      csr(2'b01, 12'h040, 64'h1234);
      trap_valid = 0; uret_valid = 0;
      csr(2'b10, 12'h040, 0);
      // back-to-back trap then uret while in REDIR
      trap(64'h2, 64'h3004, 64'h9); uret_valid = 1; step(); uret_valid = 0; step();
      // reset while in REDIR cancels the pending pulse
      trap(64'h3, 64'h4000, 64'h1);
      rst = 1; uret_valid = 1; step(); rst = 0; uret_valid = 0;
      step();
      read_all();
      // randomised traffic
      for (int n = 0; n < 3000; n++) begin
         csr_op       = 2'($urandom_range(0, 3));
         csr_addr     = pool[$urandom_range(0, 9)];
         csr_wdata    = ($urandom_range(0, 4) == 0) ? 0 : {$urandom(), $urandom()};
         trap_valid   = ($urandom_range(0, 9) == 0);
         uret_valid   = ($urandom_range(0, 9) == 0);
         trap_cause   = {1'($urandom_range(0, 1)), 55'd0, 8'($urandom())};
         trap_pc      = {$urandom(), $urandom()};
         trap_val     = {$urandom(), $urandom()};
         irq_soft_set = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 7) == 0) irq_timer = ~irq_timer;
         if ($urandom_range(0, 7) == 0) irq_ext = ~irq_ext;
         instr_retire = 1'($urandom());
         rst          = ($urandom_range(0, 199) == 0);
         step();
      end
      {csr_op, trap_valid, uret_valid, irq_soft_set, rst} = '0;
      repeat (4) step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
